// File: rtl/alu_pipe.sv
// Clocked ALU with valid/ready handshakes on both sides, registered result and flags,
// and an iterative shift-add multiplier that takes WIDTH cycles per product.
module alu_pipe #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic             busy
);
  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] acc_next_s;
  logic [WIDTH-1:0]   mplier_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   result_r;
  logic               zero_r;
  logic               carry_r;
  logic               ovf_r;
  logic               valid_r;
  logic               busy_r;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH:0]     diff_s;
  logic [WIDTH-1:0]   alu_res_s;
  logic               alu_carry_s;
  logic               alu_ovf_s;

  // Both adder forms keep the carry in bit WIDTH; subtraction borrows when that carry is clear.
  assign sum_s      = {1'b0, op_a} + {1'b0, op_b};
  assign diff_s     = {1'b0, op_a} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};
  assign acc_next_s = mplier_r[0] ? (acc_r + mcand_r) : acc_r;

  // Single-cycle datapath for every opcode except multiply
  always_comb begin
    alu_res_s   = {WIDTH{1'b0}};
    alu_carry_s = 1'b0;
    alu_ovf_s   = 1'b0;
    case (opcode)
      3'b000: begin
        alu_res_s   = sum_s[WIDTH-1:0];
        alu_carry_s = sum_s[WIDTH];
        alu_ovf_s   = (op_a[MSB] == op_b[MSB]) && (sum_s[MSB] != op_a[MSB]);
      end
      3'b010: begin
        alu_res_s   = diff_s[WIDTH-1:0];
        alu_carry_s = ~diff_s[WIDTH];
        alu_ovf_s   = (op_a[MSB] != op_b[MSB]) && (diff_s[MSB] != op_a[MSB]);
      end
      3'b011:  alu_res_s = op_a & op_b;
      3'b100:  alu_res_s = op_a ^ op_b;
      3'b101:  alu_res_s = op_a | op_b;
      3'b110:  alu_res_s = op_b;
      3'b111:  alu_res_s = ~op_a;
      default: alu_res_s = {WIDTH{1'b0}};
    endcase
  end

  // Control FSM, multiplier datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      mcand_r  <= {(2*WIDTH){1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      result_r <= {WIDTH{1'b0}};
      zero_r   <= 1'b0;
      carry_r  <= 1'b0;
      ovf_r    <= 1'b0;
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            if (opcode == 3'b001) begin
              mcand_r  <= {{WIDTH{1'b0}}, op_a};
              mplier_r <= op_b;
              acc_r    <= {(2*WIDTH){1'b0}};
              cnt_r    <= {CNT_W{1'b0}};
              busy_r   <= 1'b1;
              state_r  <= MUL;
            end else begin
              result_r <= alu_res_s;
              zero_r   <= (alu_res_s == {WIDTH{1'b0}});
              carry_r  <= alu_carry_s;
              ovf_r    <= alu_ovf_s;
              valid_r  <= 1'b1;
              state_r  <= DONE;
            end
          end
        end
        MUL: begin
          acc_r    <= acc_next_s;
          mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
          cnt_r    <= cnt_r + CNT_W'(1);
          // Last iteration: publish the product including this cycle's partial sum
          if (cnt_r == CNT_W'(WIDTH - 1)) begin
            result_r <= acc_next_s[WIDTH-1:0];
            zero_r   <= (acc_next_s[WIDTH-1:0] == {WIDTH{1'b0}});
            carry_r  <= |acc_next_s[2*WIDTH-1:WIDTH];
            ovf_r    <= 1'b0;
            valid_r  <= 1'b1;
            busy_r   <= 1'b0;
            state_r  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            valid_r <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state_r == IDLE);
  assign out_valid  = valid_r;
  assign result     = result_r;
  assign flag_zero  = zero_r;
  assign flag_carry = carry_r;
  assign flag_ovf   = ovf_r;
  assign busy       = busy_r;
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe at WIDTH 16, 8 and 32: directed vectors plus a model-checked sweep.
module tb_alu_pipe;
  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        v;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        ordy  = 1'b1;
  logic [2:0]  iv    = 3'd0;
  logic [2:0]  opc   = 3'd0;
  logic [31:0] a_bus = 32'd0;
  logic [31:0] b_bus = 32'd0;
  wire  [2:0]  ir, ov, zf, cf, vf, bz;
  wire  [15:0] r16;
  wire  [7:0]  r8;
  wire  [31:0] r32;
  int          cyc   = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  bit          seen [3];
  exp_t        q0 [$];
  exp_t        q1 [$];
  exp_t        q2 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_pipe #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .op_a(a_bus[15:0]), .op_b(b_bus[15:0]), .opcode(opc),
    .out_valid(ov[0]), .out_ready(ordy), .result(r16),
    .flag_zero(zf[0]), .flag_carry(cf[0]), .flag_ovf(vf[0]), .busy(bz[0])
  );
  alu_pipe #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .op_a(a_bus[7:0]), .op_b(b_bus[7:0]), .opcode(opc),
    .out_valid(ov[1]), .out_ready(ordy), .result(r8),
    .flag_zero(zf[1]), .flag_carry(cf[1]), .flag_ovf(vf[1]), .busy(bz[1])
  );
  alu_pipe #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .op_a(a_bus), .op_b(b_bus), .opcode(opc),
    .out_valid(ov[2]), .out_ready(ordy), .result(r32),
    .flag_zero(zf[2]), .flag_carry(cf[2]), .flag_ovf(vf[2]), .busy(bz[2])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] r, input logic z, input logic c, input logic v, input int lat);
    exp_t e;
    e.res = r; e.z = z; e.c = c; e.v = v; e.lat = lat; e.acc = 0;
    return e;
  endfunction

  // Reference model built on plain 64-bit integer arithmetic and signed range checks
  function automatic exp_t model(input int w, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint unsigned m, ua, ub, full;
    longint half, sa, sb, s;
    m    = (64'd1 << w) - 64'd1;
    ua   = {32'd0, a} & m;
    ub   = {32'd0, b} & m;
    half = longint'(64'd1 << (w - 1));
    sa   = (longint'(ua) >= half) ? longint'(ua) - 2 * half : longint'(ua);
    sb   = (longint'(ub) >= half) ? longint'(ub) - 2 * half : longint'(ub);
    e.c  = 1'b0;
    e.v  = 1'b0;
    case (op)
      3'd0: begin full = ua + ub; e.c = ((full >> w) != 0); s = sa + sb; e.v = (s >= half) || (s < -half); end
      3'd1: begin full = ua * ub; e.c = ((full >> w) != 0); end
      3'd2: begin full = ua - ub; e.c = (ua < ub); s = sa - sb; e.v = (s >= half) || (s < -half); end
      3'd3: full = ua & ub;
      3'd4: full = ua ^ ub;
      3'd5: full = ua | ub;
      3'd6: full = ub;
      default: full = ~ua;
    endcase
    e.res = 32'(full & m);
    e.z   = (e.res == 32'd0);
    e.lat = (op == 3'd1) ? w + 1 : 1;
    e.acc = 0;
    return e;
  endfunction

  function automatic int qsize(input int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qfront(input int i);
    case (i)
      0: return q0[0];
      1: return q1[0];
      default: return q2[0];
    endcase
  endfunction

  function automatic exp_t qpop(input int i);
    exp_t e;
    case (i)
      0: e = q0.pop_front();
      1: e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
    return e;
  endfunction

  function automatic logic [31:0] res_of(input int i);
    case (i)
      0: return {16'd0, r16};
      1: return {24'd0, r8};
      default: return r32;
    endcase
  endfunction

  // Monitor: latency on the first valid cycle, result and flags at the handshake
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (rst_n && ov[i]) begin
        if (qsize(i) == 0) begin
          chk($sformatf("unexpected_out%0d", i), {31'd0, ov[i]}, 32'd0);
        end else begin
          e = qfront(i);
          if (!seen[i]) begin
            seen[i] = 1'b1;
            chk($sformatf("latency%0d", i), 32'(cyc - e.acc + 1), 32'(e.lat));
          end
          if (ordy) begin
            e = qpop(i);
            seen[i] = 1'b0;
            chk($sformatf("result%0d", i), res_of(i), e.res);
            chk($sformatf("zero%0d", i), {31'd0, zf[i]}, {31'd0, e.z});
            chk($sformatf("carry%0d", i), {31'd0, cf[i]}, {31'd0, e.c});
            chk($sformatf("ovf%0d", i), {31'd0, vf[i]}, {31'd0, e.v});
          end
        end
      end
    end
  end

  task automatic issue(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input exp_t e, input bit push);
    int n;
    exp_t x;
    x = e;
    @(negedge clk);
    a_bus = a; b_bus = b; opc = op; iv[i] = 1'b1;
    n = 0;
    while (!ir[i] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!ir[i]) begin
      chk($sformatf("accept_timeout%0d", i), {31'd0, ir[i]}, 32'd1);
    end else begin
      x.acc = cyc + 1;
      if (push) begin
        case (i)
          0: q0.push_back(x);
          1: q1.push_back(x);
          default: q2.push_back(x);
        endcase
      end
      @(posedge clk);
      #1;
    end
    iv[i] = 1'b0;
  endtask

  task automatic settle();
    int n;
    n = 0;
    @(negedge clk);
    while ((ov != 3'd0 || (q0.size() + q1.size() + q2.size()) != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    logic [2:0] op;
    logic [31:0] a, b;
    #12;
    chk("reset_result", {16'd0, r16}, 32'd0);
    chk("reset_out_valid", {29'd0, ov}, 32'd0);
    chk("reset_flags_busy", {28'd0, zf[0], cf[0], vf[0], bz[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {29'd0, ir}, 32'd7);

    issue(0, 3'b000, 32'hFFFF, 32'h0001, mk(32'h0000, 1'b1, 1'b1, 1'b0, 1), 1'b1);
    issue(0, 3'b000, 32'h7FFF, 32'h0001, mk(32'h8000, 1'b0, 1'b0, 1'b1, 1), 1'b1);
    issue(0, 3'b010, 32'h0003, 32'h0005, mk(32'hFFFE, 1'b0, 1'b1, 1'b0, 1), 1'b1);
    issue(0, 3'b010, 32'h8000, 32'h0001, mk(32'h7FFF, 1'b0, 1'b0, 1'b1, 1), 1'b1);
    issue(0, 3'b001, 32'h0100, 32'h0100, mk(32'h0000, 1'b1, 1'b1, 1'b0, 17), 1'b1);
    n = 0;
    @(negedge clk);
    while (bz[0] && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", 32'(n), 32'd16);
    issue(0, 3'b001, 32'h00FF, 32'h0003, mk(32'h02FD, 1'b0, 1'b0, 1'b0, 17), 1'b1);
    issue(0, 3'b101, 32'hA000, 32'h0005, mk(32'hA005, 1'b0, 1'b0, 1'b0, 1), 1'b1);
    issue(0, 3'b110, 32'h1111, 32'h5A5A, mk(32'h5A5A, 1'b0, 1'b0, 1'b0, 1), 1'b1);
    issue(0, 3'b111, 32'h00FF, 32'h1234, mk(32'hFF00, 1'b0, 1'b0, 1'b0, 1), 1'b1);
    settle();

    // Backpressure: result must hold and a second request must wait for the handshake
    ordy = 1'b0;
    issue(0, 3'b011, 32'hF0F0, 32'h0FF0, mk(32'h00F0, 1'b0, 1'b0, 1'b0, 1), 1'b1);
    a_bus = 32'h1234; b_bus = 32'h00FF; opc = 3'b100; iv[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_result", {16'd0, r16}, 32'h00F0);
      chk("bp_in_ready", {31'd0, ir[0]}, 32'd0);
    end
    @(posedge clk);
    #1 ordy = 1'b1;
    issue(0, 3'b100, 32'h1234, 32'h00FF, mk(32'h12CB, 1'b0, 1'b0, 1'b0, 1), 1'b1);
    settle();

    // Reset in the middle of a multiply must discard it
    issue(0, 3'b001, 32'h0003, 32'h0005, mk(32'h000F, 1'b0, 1'b0, 1'b0, 17), 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, ov[0]}, 32'd0);
    chk("midrst_result", {16'd0, r16}, 32'd0);
    chk("midrst_busy", {31'd0, bz[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready", {31'd0, ir[0]}, 32'd1);
    issue(0, 3'b000, 32'h0001, 32'h0001, mk(32'h0002, 1'b0, 1'b0, 1'b0, 1), 1'b1);

    issue(1, 3'b111, 32'h0F, 32'h00, mk(32'hF0, 1'b0, 1'b0, 1'b0, 1), 1'b1);
    issue(1, 3'b110, 32'h00, 32'h3C, mk(32'h3C, 1'b0, 1'b0, 1'b0, 1), 1'b1);
    issue(1, 3'b001, 32'hFF, 32'hFF, mk(32'h01, 1'b0, 1'b1, 1'b0, 9), 1'b1);
    issue(2, 3'b001, 32'hFFFF_FFFF, 32'h2, mk(32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 33), 1'b1);
    issue(2, 3'b000, 32'h7FFF_FFFF, 32'h1, mk(32'h8000_0000, 1'b0, 1'b0, 1'b1, 1), 1'b1);
    for (int k = 0; k < 16; k++) begin
      op = 3'(k);
      a  = $urandom;
      b  = $urandom;
      issue(1, op, a, b, model(8, op, a, b), 1'b1);
      a  = $urandom;
      b  = $urandom;
      issue(2, op, a, b, model(32, op, a, b), 1'b1);
    end
    settle();
    chk("scoreboard_drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
